seg_scan: RTL

Six-digit multiplexed seven-segment display driver that consumes the 24-bit packed BCD value produced by the timer stage and drives the board's common-anode display. One digit is lit at a time, round-robin, at a parameterised per-digit refresh rate. Each frame uses a snapshot of the input so the display never tears, and each digit switch is preceded by a one-cycle anti-ghosting blank. Optional leading-zero blanking and per-digit decimal points are supported.

---
 rtl/seg_scan.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - six-digit multiplexed seven-segment scan driver
//
// Lights one digit of a six-digit common-anode display at a time, round-robin,
// one slot of DIV = CLK_FREQ/SCAN_FREQ clocks per digit. The BCD input and the
// decimal-point mask are snapshotted at the start of every frame so a frame
// never mixes two input values. The first clock of every slot is a blank
// (anti-ghosting) cycle.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   data     packed BCD, data[4k+3:4k] is digit k (k=0 rightmost)
//   dp_mask  bit k lights the decimal point of digit k
//   en       1 = display on, 0 = outputs inactive (scan keeps running)
//   seg      registered segments, seg[7]=dp, seg[6:0]=g..a
//   sel      registered digit enables, sel[k] drives digit k

module seg_scan #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int SCAN_FREQ      = 1000,
  parameter bit LZ_BLANK       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] data,
  input  logic [5:0]  dp_mask,
  input  logic        en,
  output logic [7:0]  seg,
  output logic [5:0]  sel
);

  localparam int DIV = CLK_FREQ / SCAN_FREQ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0] SEL_OFF = SEL_ACTIVE_LOW ? 6'h3F : 6'h00;

  generate
    if (DIV < 2) begin : g_div_check
      $error("seg_scan: CLK_FREQ/SCAN_FREQ must be at least 2");
    end
  endgenerate

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // invalid BCD shows a dash
    endcase
    return s;
  endfunction

  // running is low only between reset release and the first edge; that edge
  // holds the counters at slot 0 / count 0 so it "starts" the first slot.
  logic          running;
  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [23:0]   snap_data;
  logic [5:0]    snap_dp;
  logic          frame_start;

  assign frame_start = !running || ((div_cnt == DIV_LAST) && (idx == 3'd5));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      div_cnt <= '0;
      idx     <= 3'd0;
    end else if (!running) begin
      running <= 1'b1;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_data <= 24'h0;
      snap_dp   <= 6'h0;
    end else if (frame_start) begin
      snap_data <= data;
      snap_dp   <= dp_mask;
    end
  end

  // lead_zero[k]: snapshot digits k..5 are all zero
  logic [5:0] lead_zero;
  genvar gk;
  generate
    for (gk = 0; gk < 6; gk++) begin : g_lz
      assign lead_zero[gk] = (snap_data[23:4*gk] == '0);
    end
  endgenerate

  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       cur_lz;
  logic [5:0] sel_hi;
  logic [6:0] glyph;
  logic [7:0] seg_hi;
  logic [7:0] seg_d;
  logic [5:0] sel_d;

  always_comb begin
    cur_digit = 4'(snap_data >> {idx, 2'b00});
    cur_dp    = snap_dp[0];
    cur_lz    = lead_zero[0];
    sel_hi    = 6'(6'd1 << idx);
    glyph     = bcd_to_seg(cur_digit);
    seg_hi    = 8'h00;
    seg_d     = SEG_OFF;
    sel_d     = SEL_OFF;

    cur_dp = 1'(snap_dp >> idx);
    cur_lz = 1'(lead_zero >> idx);
    if (LZ_BLANK && (idx != 3'd0) && cur_lz) begin
      glyph = 7'h00;  // dp stays independent of blanking
    end
    seg_hi = {cur_dp, glyph};

    if (en && (div_cnt != '0)) begin
      seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      sel_d = SEL_ACTIVE_LOW ? ~sel_hi : sel_hi;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF;
      sel <= SEL_OFF;
    end else begin
      seg <= seg_d;
      sel <= sel_d;
    end
  end

endmodule
